// File: rtl/seq_hit_counter.sv
// seq_hit_counter: counts one-cycle match pulses from the sequence detector
// in a 2-digit BCD counter (00-99). The count is shown on a 2-digit
// multiplexed active-low seven-segment display. The block keeps a sticky
// overflow flag and accepts a synchronous clear.
//
// Ports:
//   clk        system clock, rising edge
//   clr_n      asynchronous active-low reset
//   hit        match pulse, sampled on every clk edge
//   count_clr  synchronous clear of the count and ovf (wins over hit)
//   count_bcd  [7:4] tens, [3:0] ones, BCD
//   ovf        sticky, set by a hit while the count is 99
//   seg        active-low segments, bit0=a .. bit6=g
//   an         active-low digit enables, an[0]=ones, an[1]=tens
//
// Parameters:
//   WRAP       1: 99 wraps to 00 on the next hit, 0: saturates at 99
//   SCAN_DIV   clock cycles per digit phase (>= 2)
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  blanks the tens digit when it is 0
module seq_hit_counter #(
    parameter int unsigned WRAP     = 1,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       hit,
    input  logic       count_clr,
    output logic [7:0] count_bcd,
    output logic       ovf,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } dig_e;

    logic [3:0]        ones_q, ones_d;
    logic [3:0]        tens_q, tens_d;
    logic              ovf_q, ovf_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    dig_e              sel_q, sel_d;
    logic [1:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        shown_digit;

    // Active-low gfedcba decode; codes A-F cannot occur and fall back to blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // BCD count with clear priority, wrap/saturate at 99 and sticky overflow.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        ovf_d  = ovf_q;
        if (count_clr) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
            ovf_d  = 1'b0;
        end else if (hit) begin
            if (ones_q != 4'd9) begin
                ones_d = ones_q + 4'd1;
            end else if (tens_q != 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ovf_d = 1'b1;
                if (WRAP != 0) begin
                    ones_d = 4'd0;
                    tens_d = 4'd0;
                end
            end
        end
    end

    // Free-running scan counter; the digit select flips as it rolls over.
    always_comb begin
        scan_d = scan_q + SCAN_W'(1);
        sel_d  = sel_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            sel_d  = (sel_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
        end
    end

    // Display drive uses the next select so an/seg move on the toggle edge.
    always_comb begin
        shown_digit = (sel_d == DIG_TENS) ? tens_q : ones_q;
        an_d        = (sel_d == DIG_TENS) ? 2'b01 : 2'b10;
        seg_d       = seg_decode(shown_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if ((sel_d == DIG_TENS) && (tens_q == 4'd0)) begin
            seg_d = 7'b1111111;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
            ovf_q  <= 1'b0;
            scan_q <= '0;
            sel_q  <= DIG_ONES;
            an_q   <= 2'b10;
            seg_q  <= 7'b1000000;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
            ovf_q  <= ovf_d;
            scan_q <= scan_d;
            sel_q  <= sel_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign count_bcd = {tens_q, ones_q};
    assign ovf       = ovf_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule

// File: tb/tb_seq_hit_counter.sv
// Directed bench for seq_hit_counter: two instances (wrap and saturate)
// share the same stimulus, both with a short scan period of 4 cycles.
module tb_seq_hit_counter;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       hit;
    logic       count_clr;
    logic [7:0] count_a, count_b;
    logic       ovf_a, ovf_b;
    logic [6:0] seg_a, seg_b;
    logic [1:0] an_a, an_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_hit_counter #(.WRAP(1), .SCAN_DIV(4)) u_wrap (
        .clk(clk), .clr_n(clr_n), .hit(hit), .count_clr(count_clr),
        .count_bcd(count_a), .ovf(ovf_a), .seg(seg_a), .an(an_a)
    );

    seq_hit_counter #(.WRAP(0), .SCAN_DIV(4)) u_sat (
        .clk(clk), .clr_n(clr_n), .hit(hit), .count_clr(count_clr),
        .count_bcd(count_b), .ovf(ovf_b), .seg(seg_b), .an(an_b)
    );

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] TENS_ZERO_SEG = 8'h7f;
`else
    localparam logic [7:0] TENS_ZERO_SEG = 8'h40;
`endif

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hits(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            hit = 1'b1;
            tick();
            hit = 1'b0;
            if (gap) tick();
        end
    endtask

    task automatic clear_count();
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
    endtask

    task automatic wait_an(input logic [1:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (an_a == want) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] first;
        logic [1:0] e;
        bit         ok;

        clr_n     = 1'b0;
        hit       = 1'b0;
        count_clr = 1'b0;

        // Reset values, during and after reset
        tick(); tick(); tick();
        check("rst_hold_count", count_a, 8'h00);
        check("rst_hold_an", 8'(an_a), 8'h02);
        clr_n = 1'b1;
        tick();
        check("rst_count", count_a, 8'h00);
        check("rst_ovf", 8'(ovf_a), 8'h00);
        check("rst_an", 8'(an_a), 8'h02);
        check("rst_seg", 8'(seg_a), 8'h40);

        // Asynchronous reset mid-scan, checked before any clock edge
        hits(3, 1'b0);
        tick(); tick();
        check("pre_async_count", count_a, 8'h03);
        #2 clr_n = 1'b0;
        #1;
        check("async_count", count_a, 8'h00);
        check("async_ovf", 8'(ovf_a), 8'h00);
        check("async_an", 8'(an_a), 8'h02);
        check("async_seg", 8'(seg_a), 8'h40);
        #1 clr_n = 1'b1;
        tick();

        // 12 single pulses then one 3-cycle-wide pulse
        hits(12, 1'b1);
        check("pulse12_count", count_a, 8'h12);
        hit = 1'b1;
        tick(); tick(); tick();
        hit = 1'b0;
        check("wide_count", count_a, 8'h15);
        check("wide_ovf", 8'(ovf_a), 8'h00);

        // Boundary at 99: wrap vs saturate
        clear_count();
        hits(99, 1'b0);
        check("h99_wrap_count", count_a, 8'h99);
        check("h99_wrap_ovf", 8'(ovf_a), 8'h00);
        check("h99_sat_count", count_b, 8'h99);
        hits(1, 1'b0);
        check("h100_wrap_count", count_a, 8'h00);
        check("h100_wrap_ovf", 8'(ovf_a), 8'h01);
        check("h100_sat_count", count_b, 8'h99);
        check("h100_sat_ovf", 8'(ovf_b), 8'h01);
        hits(5, 1'b0);
        check("h105_wrap_count", count_a, 8'h05);
        check("h105_wrap_ovf", 8'(ovf_a), 8'h01);
        check("h105_sat_count", count_b, 8'h99);
        check("h105_sat_ovf", 8'(ovf_b), 8'h01);

        // Clear beats a simultaneous hit and drops ovf
        hits(32, 1'b0);
        check("c37_count", count_a, 8'h37);
        check("c37_ovf", 8'(ovf_a), 8'h01);
        hit       = 1'b1;
        count_clr = 1'b1;
        tick();
        hit       = 1'b0;
        count_clr = 1'b0;
        check("clr_count", count_a, 8'h00);
        check("clr_ovf", 8'(ovf_a), 8'h00);
        check("clr_sat_count", count_b, 8'h00);
        check("clr_sat_ovf", 8'(ovf_b), 8'h00);
        hits(1, 1'b0);
        check("after_clr_count", count_a, 8'h01);

        // Scan of 25: 4-cycle phases, one digit enabled at a time
        hits(24, 1'b0);
        check("c25_count", count_a, 8'h25);
        tick(); tick();
        first = an_a;
        ok    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (an_a != first) begin
                ok = 1'b1;
                break;
            end
        end
        check("scan_toggle_seen", 8'(ok), 8'h01);
        first = an_a;
        for (int i = 0; i < 9; i++) begin
            e = (((i / 4) % 2) == 0) ? first : ~first;
            check("scan_an", 8'(an_a), 8'(e));
            check("scan_an_sat", 8'(an_b), 8'(e));
            check("scan_one_low", 8'($countones(~an_a)), 8'h01);
            check("scan_seg", 8'(seg_a), (e == 2'b10) ? 8'h12 : 8'h24);
            tick();
        end

        // Tens digit of zero: blanked or shown as 0 depending on build
        clear_count();
        hits(7, 1'b0);
        check("c07_count", count_a, 8'h07);
        tick(); tick();
        wait_an(2'b01, ok);
        check("wait_tens", 8'(ok), 8'h01);
        check("tens_zero_seg", 8'(seg_a), TENS_ZERO_SEG);
        wait_an(2'b10, ok);
        check("wait_ones", 8'(ok), 8'h01);
        check("ones7_seg", 8'(seg_a), 8'h78);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
